length_packing_ctrl: RTL and testbench
======================================

Name: length_packing_ctrl

Overview:
- Sequencer for the length-packing stage of the compressor.
- Tracks how many compressed bits sit in the OUT_WIDTH-bit packing window, and drives the packing pipeline register's control flags: store, shift, output, stop/push, fill, done and finish.
- Sits between the length/encode stage, which supplies per-word total_length, and the packing register/datapath. It also handshakes with the downstream block consumer.

Parameters:
- OUT_WIDTH, 128, packed output block width in bits; must be a power of two, at most 128.
- LEN_W, 7, width of the per-word compressed length.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream word available (its length is on i_total_length).
- i_total_length  in  LEN_W  compressed bits for this word; legal range 1..64.
- i_last  in  1  qualifies i_valid: this is the final word of the stream.
- i_out_ready  in  1  downstream can accept a full block this cycle.
- o_ready  out  1  controller accepts the word on i_valid this cycle.
- o_store_flag  out  1  write the current word into the window.
- o_shift_amount  out  8  bit offset at which the word is stored (the current fill count).
- o_output_flag  out  1  window holds OUT_WIDTH bits; emit the block.
- o_stop_flag  out  1  word crosses the block boundary (split).
- o_push_flag  out  1  carry the overflow bits into the next window.
- o_push_amount  out  8  number of overflow bits carried.
- o_fill_flag  out  1  select the padded block on output.
- o_fill_ctrl  out  1  zero-fill enable for bits at or above the fill count.
- o_done_flag  out  1  one-cycle pulse when the stream is fully flushed.
- o_finish_final  out  1  level; high from the final-block cycle until the next stream is accepted.
- o_fill_count  out  8  current fill count (debug and verification).

Behaviour:
- Reset (async, i_reset=0): every output is 0, state=RUN, cnt=0, pend=0.
- All flag outputs are registered: they appear the cycle after the accept/decision edge.
- Accept handshake: a word is accepted when i_valid && o_ready.
  - o_ready = (state==RUN) && !pend.
  - Any i_valid while o_ready=0 is held by upstream; the controller does not drop it.
- On accept with L=i_total_length, compute sum = cnt + L as a 9-bit sum with no truncation.
  - sum < OUT_WIDTH: store=1, shift=cnt, cnt<=sum.
  - sum == OUT_WIDTH: store=1, shift=cnt, output=1, cnt<=0.
  - sum > OUT_WIDTH: store=1, shift=cnt, output=1, stop=1, push=1, push_amount=sum-OUT_WIDTH, cnt<=sum-OUT_WIDTH.
- Output handshake:
  - If output is due and i_out_ready=0, set pend=1 and enter WAIT_OUT. o_output_flag stays high until i_out_ready=1, which clears pend and returns to RUN.
  - store, stop and push pulse for one cycle only; they are not repeated while waiting.
- i_last accepted:
  - After the above update, if the new cnt>0, go to FILL (or to WAIT_OUT first if an output is pending, then FILL).
  - If the new cnt==0, go to DONE.
- FILL:
  - Assert fill_flag, fill_ctrl, output_flag and finish_final, with shift_amount=cnt.
  - Hold until i_out_ready=1, then cnt<=0 and go to DONE.
- DONE: assert done_flag for one cycle, keep finish_final=1, return to RUN.
  - finish_final clears on the next accepted word.
- States: RUN, WAIT_OUT, FILL, DONE. No other states; any illegal encoding goes to RUN.
- i_total_length=0 or >64 is illegal. Treat it as 0 bits: no store pulse, cnt unchanged, still counted as accepted (i_last honoured).
- Simultaneous i_last with sum==OUT_WIDTH: emit the output, then go directly to DONE with no FILL.
- Reset asserted mid-operation (any state) aborts immediately. No partial block is emitted.

Decomposition:
- Package length_packing_pkg:
  - state enum pk_state_e {RUN, WAIT_OUT, FILL, DONE};
  - localparam OUT_WIDTH;
  - length and count width constants.
- One sub-module, length_packing_acc: a combinational sum/compare/overflow calculator taking cnt and L, producing next_cnt, full, split and push_amount.
- The FSM and output registers live in the top module.

Test Plan:
- Reset then 4 words of L=32, i_out_ready=1:
  - shifts 0, 32, 64, 96;
  - output_flag on the 4th word only;
  - fill_count returns to 0.
- cnt=100 then L=40:
  - stop=1, push=1, push_amount=12, output=1, shift=100;
  - fill_count becomes 12.
- Output due with i_out_ready=0 for 3 cycles:
  - o_ready=0 and output_flag held high for 3 cycles;
  - accepts resume the cycle after i_out_ready=1.
- Words L=20 and L=30 with i_last on the second:
  - FILL with shift_amount=50, fill_flag=1, fill_ctrl=1;
  - then a done_flag pulse, finish_final=1.
- cnt=64 with a last word of L=64:
  - output_flag, then DONE directly;
  - no fill_flag ever asserted.
- Assert reset while in WAIT_OUT:
  - all outputs 0 asynchronously, fill_count=0;
  - a fresh stream then packs correctly from shift 0.

Source files
------------

// File: rtl/length_packing_pkg.sv
// Shared types and constants for the length-packing controller.
// Widths are sized for a 128-bit packing window fed by words of at most 64 bits.
package length_packing_pkg;

  localparam int OUT_WIDTH = 128;
  localparam int LEN_W     = 7;
  localparam int CNT_W     = 8;
  localparam int SUM_W     = 9;
  localparam int MAX_LEN   = 64;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_OUT = 2'd1,
    FILL     = 2'd2,
    DONE     = 2'd3
  } pk_state_e;

  // Lengths of 0 or above MAX_LEN carry no bits into the window.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != {LEN_W{1'b0}}) && (len <= LEN_W'(MAX_LEN));
  endfunction

endpackage

// File: rtl/length_packing_acc.sv
// Window occupancy arithmetic: adds a word length to the fill count and
// classifies the result as partial, exactly full, or spilling over.
module length_packing_acc
  import length_packing_pkg::*;
#(
  parameter int OUT_WIDTH = length_packing_pkg::OUT_WIDTH,
  parameter int LEN_W     = length_packing_pkg::LEN_W
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [CNT_W-1:0] next_cnt_o,
  output logic             full_o,
  output logic             split_o,
  output logic [CNT_W-1:0] push_amount_o
);

  localparam logic [SUM_W-1:0] WIN = SUM_W'(OUT_WIDTH);

  logic [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0] over_s;

  // Nine-bit sum so a spill past the window is never truncated.
  always_comb begin
    sum_s         = {1'b0, cnt_i} + SUM_W'(len_i);
    over_s        = sum_s - WIN;
    full_o        = (sum_s == WIN);
    split_o       = (sum_s > WIN);
    next_cnt_o    = {CNT_W{1'b0}};
    push_amount_o = {CNT_W{1'b0}};
    if (sum_s > WIN) begin
      next_cnt_o    = over_s[CNT_W-1:0];
      push_amount_o = over_s[CNT_W-1:0];
    end else if (sum_s == WIN) begin
      next_cnt_o    = {CNT_W{1'b0}};
    end else begin
      next_cnt_o    = sum_s[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/length_packing_ctrl.sv
// Length-packing sequencer: tracks window occupancy and drives the registered
// store/shift/output/split/fill/done controls of the packing datapath.
module length_packing_ctrl
  import length_packing_pkg::*;
#(
  parameter int OUT_WIDTH = length_packing_pkg::OUT_WIDTH,
  parameter int LEN_W     = length_packing_pkg::LEN_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [LEN_W-1:0] i_total_length,
  input  logic             i_last,
  input  logic             i_out_ready,
  output logic             o_ready,
  output logic             o_store_flag,
  output logic [7:0]       o_shift_amount,
  output logic             o_output_flag,
  output logic             o_stop_flag,
  output logic             o_push_flag,
  output logic [7:0]       o_push_amount,
  output logic             o_fill_flag,
  output logic             o_fill_ctrl,
  output logic             o_done_flag,
  output logic             o_finish_final,
  output logic [7:0]       o_fill_count
);

  pk_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             last_q, last_d;
  logic             finish_q, finish_d;
  logic             ready_q, ready_d;
  logic             store_q, store_d;
  logic [CNT_W-1:0] shift_q, shift_d;
  logic             output_q, output_d;
  logic             stop_q, stop_d;
  logic             push_q, push_d;
  logic [CNT_W-1:0] pamt_q, pamt_d;
  logic             fill_q, fill_d;
  logic             fill_ctrl_q, fill_ctrl_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic             legal_s;
  logic [LEN_W-1:0] eff_len_s;
  logic [CNT_W-1:0] acc_next_s;
  logic             acc_full_s;
  logic             acc_split_s;
  logic [CNT_W-1:0] acc_pamt_s;
  logic             due_s;

  // Illegal lengths are folded to zero so they cost no window bits.
  always_comb begin
    accept_s = i_valid && ready_q;
    legal_s  = len_legal(i_total_length);
    if (legal_s) begin
      eff_len_s = i_total_length;
    end else begin
      eff_len_s = {LEN_W{1'b0}};
    end
    due_s = acc_full_s || acc_split_s;
  end

  length_packing_acc #(
    .OUT_WIDTH (OUT_WIDTH),
    .LEN_W     (LEN_W)
  ) u_acc (
    .cnt_i         (cnt_q),
    .len_i         (eff_len_s),
    .next_cnt_o    (acc_next_s),
    .full_o        (acc_full_s),
    .split_o       (acc_split_s),
    .push_amount_o (acc_pamt_s)
  );

  // Next-state and next-output decode; every flag is registered below.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    last_d      = last_q;
    finish_d    = finish_q;
    store_d     = 1'b0;
    shift_d     = {CNT_W{1'b0}};
    output_d    = 1'b0;
    stop_d      = 1'b0;
    push_d      = 1'b0;
    pamt_d      = {CNT_W{1'b0}};
    fill_d      = 1'b0;
    fill_ctrl_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      RUN: begin
        if (accept_s) begin
          store_d  = legal_s;
          if (legal_s) begin
            shift_d = cnt_q;
          end else begin
            shift_d = {CNT_W{1'b0}};
          end
          output_d = due_s;
          stop_d   = acc_split_s;
          push_d   = acc_split_s;
          pamt_d   = acc_pamt_s;
          cnt_d    = acc_next_s;
          last_d   = i_last && due_s && !i_out_ready;
          finish_d = i_last && due_s && (acc_next_s == {CNT_W{1'b0}});
          if (due_s && !i_out_ready) begin
            pend_d  = 1'b1;
            state_d = WAIT_OUT;
          end else if (i_last) begin
            if (acc_next_s != {CNT_W{1'b0}}) begin
              state_d = FILL;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      WAIT_OUT: begin
        if (i_out_ready) begin
          pend_d   = 1'b0;
          output_d = 1'b0;
          last_d   = 1'b0;
          if (last_q) begin
            if (cnt_q != {CNT_W{1'b0}}) begin
              state_d = FILL;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = RUN;
          end
        end else begin
          output_d = 1'b1;
        end
      end
      FILL: begin
        fill_d      = 1'b1;
        fill_ctrl_d = 1'b1;
        output_d    = 1'b1;
        finish_d    = 1'b1;
        shift_d     = cnt_q;
        if (i_out_ready) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      DONE: begin
        done_d   = 1'b1;
        finish_d = 1'b1;
        state_d  = RUN;
      end
      default: begin
        state_d  = RUN;
        cnt_d    = {CNT_W{1'b0}};
        pend_d   = 1'b0;
        last_d   = 1'b0;
        finish_d = 1'b0;
      end
    endcase
    ready_d = (state_d == RUN) && !pend_d;
  end

  // State and output registers; reset drops everything including o_ready.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= RUN;
      cnt_q       <= {CNT_W{1'b0}};
      pend_q      <= 1'b0;
      last_q      <= 1'b0;
      finish_q    <= 1'b0;
      ready_q     <= 1'b0;
      store_q     <= 1'b0;
      shift_q     <= {CNT_W{1'b0}};
      output_q    <= 1'b0;
      stop_q      <= 1'b0;
      push_q      <= 1'b0;
      pamt_q      <= {CNT_W{1'b0}};
      fill_q      <= 1'b0;
      fill_ctrl_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      last_q      <= last_d;
      finish_q    <= finish_d;
      ready_q     <= ready_d;
      store_q     <= store_d;
      shift_q     <= shift_d;
      output_q    <= output_d;
      stop_q      <= stop_d;
      push_q      <= push_d;
      pamt_q      <= pamt_d;
      fill_q      <= fill_d;
      fill_ctrl_q <= fill_ctrl_d;
      done_q      <= done_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_store_flag   = store_q;
  assign o_shift_amount = shift_q;
  assign o_output_flag  = output_q;
  assign o_stop_flag    = stop_q;
  assign o_push_flag    = push_q;
  assign o_push_amount  = pamt_q;
  assign o_fill_flag    = fill_q;
  assign o_fill_ctrl    = fill_ctrl_q;
  assign o_done_flag    = done_q;
  assign o_finish_final = finish_q;
  assign o_fill_count   = cnt_q;

endmodule

// File: tb/tb_length_packing_ctrl.sv
// Scoreboard bench for length_packing_ctrl: a bit-stream reference model queues
// expected store/fill/done events; a negedge monitor pops and compares them.
module tb_length_packing_ctrl;

  localparam int W = 128;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_valid = 1'b0;
  logic [6:0] i_total_length = 7'd0;
  logic       i_last = 1'b0;
  logic       i_out_ready = 1'b1;
  logic       o_ready, o_store_flag, o_output_flag, o_stop_flag, o_push_flag;
  logic       o_fill_flag, o_fill_ctrl, o_done_flag, o_finish_final;
  logic [7:0] o_shift_amount, o_push_amount, o_fill_count;

  length_packing_ctrl dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .i_total_length (i_total_length),
    .i_last         (i_last),
    .i_out_ready    (i_out_ready),
    .o_ready        (o_ready),
    .o_store_flag   (o_store_flag),
    .o_shift_amount (o_shift_amount),
    .o_output_flag  (o_output_flag),
    .o_stop_flag    (o_stop_flag),
    .o_push_flag    (o_push_flag),
    .o_push_amount  (o_push_amount),
    .o_fill_flag    (o_fill_flag),
    .o_fill_ctrl    (o_fill_ctrl),
    .o_done_flag    (o_done_flag),
    .o_finish_final (o_finish_final),
    .o_fill_count   (o_fill_count)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          total_bits = 0;
  bit          ready_mode = 1'b0;
  logic        ready_force = 1'b1;
  logic        fill_prev = 1'b0;

  function automatic logic [31:0] ev(input int kind, input int a, input int b,
                                     input int c, input int d, input int e);
    return {kind[1:0], a[7:0], b[0], c[0], d[0], e[7:0], 11'd0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got event %0h expected none", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, {32'd0, act}, {32'd0, e});
    end
  endtask

  // Reference model: the stream is a sequence of bits cut into W-bit blocks.
  task automatic model_accept(input int len, input bit last);
    int b0, b1, rem;
    bit outf, split;
    if (len >= 1 && len <= 64) begin
      b0 = total_bits / W;
      rem = total_bits % W;
      total_bits += len;
      b1 = total_bits / W;
      outf = (b1 > b0);
      split = outf && ((total_bits % W) != 0);
      exp_q.push_back(ev(0, rem, outf, split, split, split ? (total_bits % W) : 0));
    end
    if (last) begin
      if ((total_bits % W) != 0) exp_q.push_back(ev(1, total_bits % W, 1, 1, 1, 0));
      exp_q.push_back(ev(2, 0, 1, 0, 0, 0));
      total_bits = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_word(input int len, input bit last);
    int waited;
    waited = 0;
    i_valid = 1'b1;
    i_total_length = len[6:0];
    i_last = last;
    while (!o_ready && waited < 300) begin
      tick(1);
      waited++;
    end
    if (!o_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: o_ready=0 after %0d cycles, required 1", waited);
    end else begin
      model_accept(len, last);
      tick(1);
    end
    i_valid = 1'b0;
    i_last = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {31'd0, o_ready, o_store_flag, o_shift_amount, o_output_flag, o_stop_flag,
            o_push_flag, o_push_amount, o_fill_flag, o_fill_ctrl, o_done_flag,
            o_finish_final, o_fill_count};
  endfunction

  always @(negedge i_clk) begin
    i_out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: one event per store pulse, per start of a fill run, per done pulse.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      fill_prev = 1'b0;
    end else begin
      if (o_store_flag)
        pop_cmp("store", ev(0, o_shift_amount, o_output_flag, o_stop_flag, o_push_flag, o_push_amount));
      if (o_fill_flag && !fill_prev)
        pop_cmp("fill", ev(1, o_shift_amount, o_output_flag, o_fill_ctrl, o_finish_final, 0));
      if (o_done_flag)
        pop_cmp("done", ev(2, o_fill_count, o_finish_final, 0, 0, 0));
      fill_prev = o_fill_flag;
    end
  end

  initial begin
    int nw, len, r, w;
    #12;
    check("reset_outputs", all_outs(), 64'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    tick(1);

    for (int i = 0; i < 4; i++) send_word(32, 1'b0);
    check("four32_fill_count", {56'd0, o_fill_count}, 64'd0);

    send_word(50, 1'b0);
    send_word(50, 1'b0);
    check("cnt100", {56'd0, o_fill_count}, 64'd100);
    send_word(40, 1'b0);
    check("split_fill_count", {56'd0, o_fill_count}, 64'd12);
    send_word(64, 1'b0);
    send_word(52, 1'b0);
    check("realign_fill_count", {56'd0, o_fill_count}, 64'd0);

    send_word(64, 1'b0);
    ready_force = 1'b0;
    send_word(64, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("stall_output_held", {63'd0, o_output_flag}, 64'd1);
      check("stall_ready_low", {63'd0, o_ready}, 64'd0);
      if (k == 2) ready_force = 1'b1;
      tick(1);
    end
    check("stall_release_output", {63'd0, o_output_flag}, 64'd0);
    check("stall_release_ready", {63'd0, o_ready}, 64'd1);

    send_word(20, 1'b0);
    send_word(30, 1'b1);
    tick(6);
    check("finish_held", {63'd0, o_finish_final}, 64'd1);

    send_word(64, 1'b0);
    check("finish_cleared", {63'd0, o_finish_final}, 64'd0);
    send_word(64, 1'b1);
    tick(4);

    send_word(64, 1'b0);
    ready_force = 1'b0;
    send_word(64, 1'b0);
    i_reset = 1'b0;
    #1;
    check("reset_in_wait_out", all_outs(), 64'd0);
    exp_q.delete();
    total_bits = 0;
    ready_force = 1'b1;
    tick(1);
    i_reset = 1'b1;
    tick(1);
    send_word(10, 1'b0);
    send_word(10, 1'b1);
    tick(5);

    ready_mode = 1'b1;
    for (int s = 0; s < 40; s++) begin
      nw = $urandom_range(1, 10);
      for (int i = 0; i < nw; i++) begin
        r = $urandom_range(0, 19);
        if (r == 0) len = 0;
        else if (r == 1) len = $urandom_range(65, 127);
        else len = $urandom_range(1, 64);
        send_word(len, i == nw - 1);
        tick($urandom_range(0, 2));
      end
    end

    ready_mode = 1'b0;
    ready_force = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      tick(1);
      w++;
    end
    check("drain_events", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
